// File: rtl/fsk_demod_rx.sv
// fsk_demod_rx: FSK demodulator and 16-bit UART-style word deframer.
//   Measures the time between line edges to classify mark (short half-period)
//   versus space (long half-period), then deframes start + 16 data (LSB first)
//   + stop bits. A good word is presented on data_out with a one-cycle
//   data_valid. A bad stop bit or a mid-frame carrier loss gives a one-cycle
//   frame_err instead.
// Ports: clk, reset (async, active-low), fsk_in (async line input),
//   data_out[15:0], data_valid, frame_err, carrier_ok, busy.
module fsk_demod_rx #(
  parameter int BIT_CYCLES  = 1000,
  parameter int HALF_THRESH = 75,
  parameter int MAX_HALF    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fsk_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        carrier_ok,
  output logic        busy
);

  localparam logic [15:0] HALF_BIT_M1 = 16'(BIT_CYCLES / 2 - 1);
  localparam logic [15:0] FULL_BIT_M1 = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] THRESH      = 16'(HALF_THRESH);
  localparam logic [15:0] MAXH        = 16'(MAX_HALF);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [1:0]  sync_q;
  logic        prev_q;
  logic [15:0] hcnt_q;
  logic [15:0] hcnt_d;
  logic        demod_q;
  logic        carrier_q;
  state_t      state_q;
  logic [15:0] tmr_q;
  logic [15:0] tmr_d;
  logic [3:0]  idx_q;
  logic [15:0] sreg_q;
  logic [15:0] data_q;
  logic        dv_q;
  logic        fe_q;
  logic        line_edge;

  // Both-edge detect on the synchronized line.
  assign line_edge = sync_q[1] ^ prev_q;
  // Saturating increment so a dead line never wraps into a fake short half.
  assign hcnt_d    = (hcnt_q == 16'hFFFF) ? hcnt_q : hcnt_q + 16'd1;
  assign tmr_d     = tmr_q + 16'd1;

  // Input synchronizer, half-period measurement and carrier detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= 2'b00;
      prev_q    <= 1'b0;
      hcnt_q    <= 16'd0;
      demod_q   <= 1'b1;
      carrier_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], fsk_in};
      prev_q <= sync_q[1];
      if (line_edge) begin
        // hcnt holds the cycles elapsed since the previous edge.
        hcnt_q    <= 16'd1;
        demod_q   <= (hcnt_q <= THRESH);
        carrier_q <= 1'b1;
      end else begin
        hcnt_q <= hcnt_d;
        if (hcnt_q == MAXH) begin
          // Line went quiet: drop carrier and fall back to idle mark.
          carrier_q <= 1'b0;
          demod_q   <= 1'b1;
        end
      end
    end
  end

  // Frame FSM with registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmr_q   <= 16'd0;
      idx_q   <= 4'd0;
      sreg_q  <= 16'd0;
      data_q  <= 16'd0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      if (state_q == IDLE) begin
        if (carrier_q && !demod_q) begin
          state_q <= START;
          tmr_q   <= 16'd0;
        end
      end else if (!carrier_q) begin
        // Carrier loss wins over any sample due this cycle.
        state_q <= IDLE;
        fe_q    <= 1'b1;
      end else if (state_q == START) begin
        if (tmr_q == HALF_BIT_M1) begin
          tmr_q <= 16'd0;
          idx_q <= 4'd0;
          // A start bit that has turned back to mark by mid-bit is a glitch.
          state_q <= demod_q ? IDLE : DATA;
        end else begin
          tmr_q <= tmr_d;
        end
      end else if (state_q == DATA) begin
        if (tmr_q == FULL_BIT_M1) begin
          sreg_q[idx_q] <= demod_q;
          tmr_q         <= 16'd0;
          if (idx_q == 4'd15) begin
            state_q <= STOP;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end else begin
          tmr_q <= tmr_d;
        end
      end else begin
        if (tmr_q == FULL_BIT_M1) begin
          if (demod_q) begin
            data_q <= sreg_q;
            dv_q   <= 1'b1;
          end else begin
            fe_q <= 1'b1;
          end
          state_q <= IDLE;
          tmr_q   <= 16'd0;
        end else begin
          tmr_q <= tmr_d;
        end
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign carrier_ok = carrier_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/fsk_demod_rx.md
# fsk_demod_rx

Receive-side FSK demodulator and 16-bit word deframer for the FSK link. It takes the comparator-sliced 1-bit line signal and classifies each half-period as mark (high tone, logic 1) or space (low tone, logic 0). It then recovers UART-style frames (start bit, 16 data bits LSB-first, stop bit) and presents each received word with a one-cycle valid strobe. It is the counterpart of the transmit-side modulator and feeds the same 16-bit registered data path.

## Interface
Parameters:
- BIT_CYCLES, default 1000: clk cycles per bit; even number, range 4..65534.
- HALF_THRESH, default 75: a half-period of at most this many cycles is a mark (1); a longer one is a space (0).
- MAX_HALF, default 255: if no edge is seen for more than this many cycles, the carrier is lost. Must be greater than HALF_THRESH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; clock clk.
- fsk_in  input  1  sliced FSK line signal, asynchronous to clk.
- data_out  output  16  last correctly framed word; holds its value between frames.
- data_valid  output  1  one-cycle pulse; data_out is updated in the same cycle.
- frame_err  output  1  one-cycle pulse on a bad stop bit or a carrier loss mid-frame.
- carrier_ok  output  1  high while edges arrive within MAX_HALF cycles of each other.
- busy  output  1  high while the FSM is not in IDLE.

## Operation
- **Input stage:** fsk_in passes through a 2-flop synchronizer, then a registered edge detector that fires on both rising and falling edges.
- **Half-period counter hcnt:** 16 bits, saturates at 0xFFFF.
  - On an edge, hcnt loads 1; otherwise it increments.
  - On an edge, len = hcnt (the cycles since the previous edge). Then demod_bit <= (len <= HALF_THRESH), and carrier_ok <= 1.
  - When hcnt == MAX_HALF with no edge: carrier_ok <= 0 and demod_bit <= 1 (idle mark).
- **FSM states:** IDLE, START, DATA, STOP. A 16-bit bit-timer tmr, a 4-bit index idx and a 16-bit shift register sreg support it.
  - IDLE: when carrier_ok && demod_bit == 0, go to START with tmr = 0.
  - START: when tmr == BIT_CYCLES/2 − 1, sample demod_bit. If 0, go to DATA with tmr = 0 and idx = 0. If 1, return to IDLE silently (glitch rejection).
  - DATA: when tmr == BIT_CYCLES − 1, do sreg[idx] <= demod_bit and tmr <= 0. If idx == 15, go to STOP; otherwise idx++.
  - STOP: when tmr == BIT_CYCLES − 1, sample demod_bit.
    - If 1: data_out <= sreg and data_valid pulses.
    - If 0: frame_err pulses and data_out is unchanged.
    - Either way, return to IDLE.
- **Carrier loss** (carrier_ok falling) in START, DATA or STOP aborts to IDLE on the next cycle and pulses frame_err. data_out is unchanged.
- A carrier loss in the same cycle as the STOP sample is treated as a carrier loss: frame_err, no data_valid.
- busy = (state != IDLE).

## Timing
- **Reset values:** data_out = 0x0000, data_valid = 0, frame_err = 0, carrier_ok = 0, busy = 0. Internally demod_bit = 1, hcnt = 0, state = IDLE, synchronizer = 0.
- **Reset mid-frame:** the frame is dropped immediately. No pulse is issued on release.
- **Latency from a fsk_in edge to the demod_bit update:** 3 clk (2 for the synchronizer, 1 for the edge register).
- **Sampling points:** data bit k is sampled (k+1.5)·BIT_CYCLES cycles after START entry; the stop bit at 17.5·BIT_CYCLES.
- **Output strobe:** data_valid or frame_err is registered and asserted the cycle after the STOP sample; busy drops in the same cycle.
- **Back-to-back frames:** a new start bit can be accepted the cycle after returning to IDLE.
- **Threshold boundary:** len == HALF_THRESH classifies as 1; len == HALF_THRESH + 1 classifies as 0.
- **First edge after carrier loss:** it sets carrier_ok, and its len (≥ MAX_HALF + 1) classifies as 0. IDLE ignores that single half-period only if the classification is followed by a mark before the START sample.

## Test plan
Defaults apply. Mark tone = half-period 50 cycles; space tone = half-period 100 cycles.
1. **Reset:** hold reset low with fsk_in toggling -> all outputs 0 and busy 0. After release, 300 cycles with no edges -> carrier_ok stays 0.
2. **Good frame:** mark idle for 3 bits, then send 0xA5C3 framed -> exactly one data_valid pulse, data_out = 0xA5C3, frame_err never asserts, busy high for about 17.5·1000 cycles.
3. **Bad stop bit:** send 0x1234 with stop = space -> one frame_err pulse, no data_valid, data_out keeps the previous 0xA5C3.
4. **Start glitch:** 300 cycles of space tone, then mark -> busy pulses and returns to 0, with no data_valid and no frame_err.
5. **Carrier loss mid-DATA:** hold fsk_in constant for 400 cycles during bit 7 -> carrier_ok falls at hcnt = 255, then one frame_err pulse and busy 0.
6. **Threshold, then reset:** half-periods of 75 then 76 cycles -> demod_bit is 1 then 0. Then assert reset mid-frame -> outputs return to their reset values, and a following 0x00FF frame is received correctly.
